spi_master: RTL and testbench

//   SPI mode-0 initiator for the 24-bit frame handled by our SPI peripheral.

---
 rtl/spi_master.sv | 184 ++++++++++++++++++
 tb/tb_spi_master.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master.sv
// SPI mode-0 initiator: sends {adr, data_wr} MSB first with an active-high cs
// and captures the read word returned during the data phase.
module spi_master #(
  parameter int ADRSIZE     = 8,
  parameter int DATASIZE    = 16,
  parameter int HALF_PERIOD = 4
) (
  input  logic                sys_clk,
  input  logic                reset,
  input  logic                start,
  input  logic [ADRSIZE-1:0]  adr,
  input  logic [DATASIZE-1:0] data_wr,
  output logic                busy,
  output logic                done,
  output logic [DATASIZE-1:0] data_rd,
  output logic                sclk,
  output logic                mosi,
  output logic                cs,
  input  logic                miso
);

  localparam int REGSIZE = ADRSIZE + DATASIZE;
  localparam int PW      = $clog2(HALF_PERIOD + 1);
  localparam int BW      = $clog2(REGSIZE + 1);

  if (HALF_PERIOD < 4) begin : g_hp_chk
    $error("spi_master: HALF_PERIOD must be >= 4");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT,
    S_DONE,
    S_GAP
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [PW-1:0]       r_phase;
  logic [BW-1:0]       r_bit;
  logic [REGSIZE-1:0]  r_sreg;
  logic [DATASIZE-1:0] r_rd;
  logic                r_miso_m;
  logic                r_miso_s;

  logic [REGSIZE-1:0]  w_frame;
  logic                w_pend;
  logic                w_last;
  logic                w_rd_bit;
  logic                w_load;
  logic                w_rise;
  logic                w_fall;
  logic                w_finish;
  logic                w_gap_end;

  assign w_frame  = {adr, data_wr};
  assign w_pend   = (r_phase == PW'(HALF_PERIOD - 1));
  assign w_last   = (r_bit == BW'(REGSIZE));
  assign w_rd_bit = (r_bit >= BW'(ADRSIZE));

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_rise      = 1'b0;
    w_fall      = 1'b0;
    w_finish    = 1'b0;
    w_gap_end   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_SETUP;
          w_load      = 1'b1;
        end
      end
      S_SETUP: begin
        if (w_pend) begin
          w_state_nxt = S_SHIFT;
          w_rise      = 1'b1;
        end
      end
      S_SHIFT: begin
        // r_bit has already advanced past the last bit during the HOLD phase
        if (w_pend) begin
          if (sclk) begin
            w_fall = 1'b1;
          end else if (w_last) begin
            w_state_nxt = S_DONE;
            w_finish    = 1'b1;
          end else begin
            w_rise = 1'b1;
          end
        end
      end
      S_DONE: begin
        w_state_nxt = S_GAP;
      end
      S_GAP: begin
        if (w_pend) begin
          w_state_nxt = S_IDLE;
          w_gap_end   = 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      r_phase <= '0;
    end else if (r_state == S_IDLE || w_pend ||
                 w_state_nxt != r_state) begin
      r_phase <= '0;
    end else begin
      r_phase <= r_phase + PW'(1);
    end
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      r_miso_m <= 1'b0;
      r_miso_s <= 1'b0;
    end else begin
      r_miso_m <= miso;
      r_miso_s <= r_miso_m;
    end
  end

  // r_sreg holds the bits still to be sent, next bit in the MSB
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      r_sreg  <= '0;
      r_bit   <= '0;
      r_rd    <= '0;
      data_rd <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      sclk    <= 1'b0;
      mosi    <= 1'b0;
      cs      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (w_load) begin
        r_sreg <= {w_frame[REGSIZE-2:0], 1'b0};
        r_bit  <= '0;
        mosi   <= w_frame[REGSIZE-1];
        sclk   <= 1'b0;
        cs     <= 1'b1;
        busy   <= 1'b1;
      end
      if (w_rise) begin
        sclk <= 1'b1;
      end
      if (w_fall) begin
        sclk   <= 1'b0;
        mosi   <= r_sreg[REGSIZE-1];
        r_sreg <= {r_sreg[REGSIZE-2:0], 1'b0};
        r_bit  <= r_bit + BW'(1);
        if (w_rd_bit) begin
          r_rd <= {r_rd[DATASIZE-2:0], r_miso_s};
        end
      end
      if (w_finish) begin
        cs      <= 1'b0;
        done    <= 1'b1;
        data_rd <= r_rd;
      end
      if (w_gap_end) begin
        busy <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: peripheral model plus scoreboard, two instances
// (HALF_PERIOD 4 and 8) sharing reset and the address/data inputs.
module tb_spi_master;

  localparam int AW = 8;
  localparam int DW = 16;
  localparam int RW = AW + DW;

  typedef struct {
    logic [RW-1:0] frame;
    logic [DW-1:0] rd;
    int            dcyc;
  } exp_t;

  logic          sys_clk = 1'b0;
  logic          reset   = 1'b1;
  logic          start0  = 1'b0;
  logic          start1  = 1'b0;
  logic [AW-1:0] adr     = '0;
  logic [DW-1:0] data_wr = '0;
  logic [DW-1:0] per_rd  = '0;

  logic          busy_o [2];
  logic          done_o [2];
  logic          sclk_o [2];
  logic          mosi_o [2];
  logic          cs_o   [2];
  logic          miso_i [2];
  logic [DW-1:0] rd_o   [2];

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  exp_t q0[$];
  exp_t q1[$];

  logic          p_sclk [2];
  logic          p_cs   [2];
  logic          p_mosi [2];
  logic          p_done [2];
  logic [RW-1:0] rx     [2];
  logic [DW-1:0] rword  [2];
  int            run    [2];
  int            cs_hi  [2];
  int            cs_lo  [2];
  int            rises  [2];
  int            ndone  [2];
  bit            abort  [2];
  bit            seen   [2];

  spi_master #(.ADRSIZE(AW), .DATASIZE(DW), .HALF_PERIOD(4)) u_dut4 (
    .sys_clk(sys_clk), .reset(reset), .start(start0),
    .adr(adr), .data_wr(data_wr),
    .busy(busy_o[0]), .done(done_o[0]), .data_rd(rd_o[0]),
    .sclk(sclk_o[0]), .mosi(mosi_o[0]), .cs(cs_o[0]),
    .miso(miso_i[0])
  );

  spi_master #(.ADRSIZE(AW), .DATASIZE(DW), .HALF_PERIOD(8)) u_dut8 (
    .sys_clk(sys_clk), .reset(reset), .start(start1),
    .adr(adr), .data_wr(data_wr),
    .busy(busy_o[1]), .done(done_o[1]), .data_rd(rd_o[1]),
    .sclk(sclk_o[1]), .mosi(mosi_o[1]), .cs(cs_o[1]),
    .miso(miso_i[1])
  );

  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)",
               tag, obs, exp, $time);
    end
  endtask

  function automatic int hp(input int i);
    return (i == 0) ? 4 : 8;
  endfunction

  function automatic int qsz(input int i);
    return (i == 0) ? q0.size() : q1.size();
  endfunction

  function automatic logic [RW-1:0] qfront(input int i);
    if (i == 0) return q0[0].frame;
    return q1[0].frame;
  endfunction

  task automatic mon(input int i);
    exp_t e;
    logic st;
    int   h;
    h  = hp(i);
    st = (i == 0) ? start0 : start1;
    if (st && !busy_o[i] && !reset) begin
      e.frame = {adr, data_wr};
      e.rd    = per_rd;
      e.dcyc  = cyc + 1 + h * (1 + 2 * RW);
      if (i == 0) q0.push_back(e);
      else q1.push_back(e);
    end
    if (cs_o[i]) begin
      if (!p_cs[i]) begin
        if (seen[i]) chk($sformatf("cs_gap%0d", i), cs_lo[i] >= h + 1, 1);
        cs_hi[i] = 1;
        run[i]   = 1;
        rises[i] = 0;
        rx[i]    = '0;
      end else begin
        cs_hi[i]++;
        if (sclk_o[i] == p_sclk[i]) begin
          run[i]++;
        end else begin
          chk($sformatf("phase%0d", i), run[i], h);
          run[i] = 1;
        end
        chk("mosi_stable",
            (mosi_o[i] == p_mosi[i]) || (p_sclk[i] && !sclk_o[i]), 1);
      end
      if (sclk_o[i] && !p_sclk[i]) begin
        rises[i]++;
        rx[i] = {rx[i][RW-2:0], mosi_o[i]};
        if (rises[i] == AW) rword[i] = per_rd;
      end
      if (!sclk_o[i] && p_sclk[i]) begin
        if (rises[i] >= AW && rises[i] < RW)
          miso_i[i] = rword[i][RW-1-rises[i]];
        if (rises[i] == RW) chk("mosi_tail", mosi_o[i], 0);
      end
    end else begin
      miso_i[i] = 1'b0;
      if (p_cs[i]) begin
        cs_lo[i] = 1;
        if (abort[i]) begin
          abort[i] = 0;
          seen[i]  = 0;
        end else begin
          seen[i] = 1;
          chk($sformatf("hold%0d", i), run[i], h);
          chk("rises", rises[i], RW);
          chk($sformatf("cs_high%0d", i), cs_hi[i], h * (1 + 2 * RW));
          if (qsz(i) > 0) chk("mosi_frame", rx[i], qfront(i));
          else chk("frame_unexp", 1, 0);
        end
      end else begin
        cs_lo[i]++;
      end
    end
    if (done_o[i]) begin
      ndone[i]++;
      chk("done_pulse", p_done[i], 0);
      chk("busy_at_done", busy_o[i], 1);
      if (qsz(i) > 0) begin
        if (i == 0) e = q0.pop_front();
        else e = q1.pop_front();
        chk("data_rd", rd_o[i], e.rd);
        chk("done_cyc", cyc, e.dcyc);
      end else begin
        chk("done_unexp", 1, 0);
      end
    end
    p_sclk[i] = sclk_o[i];
    p_cs[i]   = cs_o[i];
    p_mosi[i] = mosi_o[i];
    p_done[i] = done_o[i];
  endtask

  always @(negedge sys_clk) begin
    mon(0);
    mon(1);
  end

  task automatic wait_idle(input int i);
    int k;
    for (k = 0; k < 1000 && busy_o[i] !== 1'b0; k++)
      @(posedge sys_clk) #1;
    chk("idle_wait", busy_o[i], 0);
  endtask

  task automatic wait_done(input int i, input int target, input int lim);
    int k;
    for (k = 0; k < lim && ndone[i] < target; k++)
      @(posedge sys_clk) #1;
    chk("done_wait", ndone[i] >= target, 1);
  endtask

  task automatic wait_rises(input int n);
    int k;
    for (k = 0; k < 1000 && rises[0] < n; k++)
      @(posedge sys_clk) #1;
    chk("rise_wait", rises[0] >= n, 1);
  endtask

  task automatic pulse_start0(input logic [AW-1:0] a,
                              input logic [DW-1:0] d);
    @(posedge sys_clk) #1;
    adr     = a;
    data_wr = d;
    start0  = 1'b1;
    @(posedge sys_clk) #1;
    start0  = 1'b0;
    adr     = ~a;
    data_wr = ~d;
  endtask

  task automatic frame(input logic [AW-1:0] a,
                       input logic [DW-1:0] d,
                       input logic [DW-1:0] r);
    int n;
    per_rd = r;
    wait_idle(0);
    n = ndone[0];
    pulse_start0(a, d);
    wait_done(0, n + 1, 1000);
  endtask

  initial begin
    int n;
    int k;
    for (int i = 0; i < 2; i++) begin
      p_sclk[i] = 1'b0;
      p_cs[i]   = 1'b0;
      p_mosi[i] = 1'b0;
      p_done[i] = 1'b0;
      miso_i[i] = 1'b0;
      rword[i]  = '0;
      rx[i]     = '0;
    end
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    for (int i = 0; i < 2; i++) begin
      chk("rst_busy", busy_o[i], 0);
      chk("rst_done", done_o[i], 0);
      chk("rst_data_rd", rd_o[i], 0);
      chk("rst_sclk", sclk_o[i], 0);
      chk("rst_mosi", mosi_o[i], 0);
      chk("rst_cs", cs_o[i], 0);
    end
    @(posedge sys_clk) #1;
    reset = 1'b0;

    repeat (20) @(negedge sys_clk);
    chk("idle_cs", cs_o[0], 0);
    chk("idle_sclk", sclk_o[0], 0);
    chk("idle_mosi", mosi_o[0], 0);
    chk("idle_busy", busy_o[0], 0);
    chk("idle_ndone", ndone[0], 0);

    frame(8'h5A, 16'hC3A5, 16'h1234);
    frame(8'h12, 16'h0000, 16'hBEEF);
    frame(8'h12, 16'hFFFF, 16'h0001);
    frame(8'h81, 16'h8001, 16'h8000);

    per_rd = 16'hA5A5;
    wait_idle(0);
    n = ndone[0];
    pulse_start0(8'h3C, 16'h0FF0);
    wait_rises(10);
    start0 = 1'b1;
    @(posedge sys_clk) #1;
    start0 = 1'b0;
    for (k = 0; k < 1000 && done_o[0] !== 1'b1; k++)
      @(posedge sys_clk) #1;
    chk("done_seen", done_o[0], 1);
    start0 = 1'b1;
    @(posedge sys_clk) #1;
    start0 = 1'b0;
    wait_idle(0);
    repeat (10) @(posedge sys_clk) #1;
    chk("one_frame", ndone[0] - n, 1);
    frame(8'hC0, 16'h7E81, 16'h6B2D);

    per_rd = 16'h3C3C;
    wait_idle(0);
    pulse_start0(8'hE7, 16'h1818);
    wait_rises(12);
    n        = ndone[0];
    abort[0] = 1;
    q0.delete();
    reset    = 1'b1;
    @(posedge sys_clk) #1;
    reset    = 1'b0;
    @(negedge sys_clk);
    chk("abort_cs", cs_o[0], 0);
    chk("abort_sclk", sclk_o[0], 0);
    chk("abort_mosi", mosi_o[0], 0);
    chk("abort_busy", busy_o[0], 0);
    repeat (250) @(negedge sys_clk);
    chk("abort_nodone", ndone[0] - n, 0);
    frame(8'h33, 16'h0F0F, 16'hF00D);

    wait_idle(1);
    per_rd = 16'h2468;
    @(posedge sys_clk) #1;
    n       = ndone[1];
    adr     = 8'h77;
    data_wr = 16'h1357;
    start1  = 1'b1;
    wait_done(1, n + 1, 1000);
    adr     = 8'h96;
    data_wr = 16'hFACE;
    wait_done(1, n + 3, 2000);
    start1  = 1'b0;
    wait_idle(1);
    repeat (20) @(posedge sys_clk) #1;
    chk("b2b_frames", ndone[1] - n, 3);

    repeat (20) @(negedge sys_clk);
    chk("sb_empty", q0.size() + q1.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
